bus_arbiter_rr: RTL and testbench

- Responder end of the core request/grant bus protocol.
- Arbitrates two cores onto the single gpiomem RAM port using round-robin fairness and a bounded tenure.
- Steers the owner's address, data and rw to the RAM, and returns synchronous read data to the requesting core with a valid strobe.
- Sits between core0/core1 and gpiomem in the top level.

---
 rtl/bus_arbiter_rr.sv | 184 ++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: two-core round-robin arbiter in front of the single gpiomem
// RAM port. It grants one core at a time, steers the owner's address, data
// and rw to the RAM, and returns synchronous read data with a one-cycle
// rvalid strobe.
//
// Handshake: a core raises coreX_request and holds it for as long as it wants
// the bus. coreX_grant is decoded from the registered FSM state, so it rises
// on the edge after the request is first sampled and the two grants are
// mutually exclusive. Every clock edge with coreX_grant=1 and coreX_request=1
// is one transfer; a read transfer produces coreX_rvalid exactly one cycle
// later, and coreX_data_out holds that value until the next rvalid.
//
// Ports:
//   clk, reset (async, active-low)
//   coreN_request/rw/address/data_in  in   core request side (N = 0,1)
//   coreN_grant/data_out/rvalid       out  core response side
//   RAM_address/RAM_data_in/rw        out  RAM command, zero outside transfers
//   RAM_data_out                      in   RAM read data, one cycle after address
//   dbg_state                         out  FSM state (0 IDLE, 1 OWN0, 2 OWN1)
module bus_arbiter_rr #(
  parameter int              CORE_AW  = 10,
  parameter int              RAM_AW   = 9,
  parameter int              DW       = 8,
  parameter int              MAX_HOLD = 16,
  parameter logic [DW-1:0]   OOR_DATA = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               core0_request,
  output logic               core0_grant,
  input  logic               core0_rw,
  input  logic [CORE_AW-1:0] core0_address,
  input  logic [DW-1:0]      core0_data_in,
  output logic [DW-1:0]      core0_data_out,
  output logic               core0_rvalid,
  input  logic               core1_request,
  output logic               core1_grant,
  input  logic               core1_rw,
  input  logic [CORE_AW-1:0] core1_address,
  input  logic [DW-1:0]      core1_data_in,
  output logic [DW-1:0]      core1_data_out,
  output logic               core1_rvalid,
  output logic [RAM_AW-1:0]  RAM_address,
  output logic [DW-1:0]      RAM_data_in,
  input  logic [DW-1:0]      RAM_data_out,
  output logic               rw,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_OWN0 = 2'd1,
    S_OWN1 = 2'd2
  } state_t;

  localparam int            TW   = $clog2(MAX_HOLD + 1);
  localparam logic [TW-1:0] TMAX = TW'(MAX_HOLD - 1);

  state_t          r_state;
  state_t          w_next;
  logic            r_last_owner;
  logic [TW-1:0]   r_tenure;
  logic            r_pend_valid;
  logic            r_pend_owner;
  logic            r_pend_oor;
  logic [DW-1:0]   r_hold0;
  logic [DW-1:0]   r_hold1;

  logic            w_xfer0;
  logic            w_xfer1;
  logic            w_oor0;
  logic            w_oor1;
  logic            w_rd;
  logic            w_sel_oor;
  logic            w_tenure_end;
  logic [DW-1:0]   w_rdata;

  assign w_oor0       = |core0_address[CORE_AW-1:RAM_AW];
  assign w_oor1       = |core1_address[CORE_AW-1:RAM_AW];
  assign w_xfer0      = (r_state == S_OWN0) & core0_request;
  assign w_xfer1      = (r_state == S_OWN1) & core1_request;
  assign w_tenure_end = (r_tenure == TMAX);

  // State register plus the bookkeeping that changes on state entry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_last_owner <= 1'b1;
      r_tenure     <= '0;
    end else begin
      r_state <= w_next;
      if (w_next != r_state) begin
        r_tenure <= '0;
        if (w_next == S_OWN0) r_last_owner <= 1'b0;
        if (w_next == S_OWN1) r_last_owner <= 1'b1;
      end else if (r_state != S_IDLE && !w_tenure_end) begin
        // Saturates at MAX_HOLD-1 while the other core stays quiet.
        r_tenure <= r_tenure + 1'b1;
      end
    end
  end

  // Next-state: round-robin on ties, direct handoff on release or tenure expiry.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (core0_request && core1_request) w_next = r_last_owner ? S_OWN0 : S_OWN1;
        else if (core0_request)             w_next = S_OWN0;
        else if (core1_request)             w_next = S_OWN1;
        else                                w_next = S_IDLE;
      end
      S_OWN0: begin
        if (!core0_request)                    w_next = core1_request ? S_OWN1 : S_IDLE;
        else if (w_tenure_end && core1_request) w_next = S_OWN1;
        else                                   w_next = S_OWN0;
      end
      S_OWN1: begin
        if (!core1_request)                    w_next = core0_request ? S_OWN0 : S_IDLE;
        else if (w_tenure_end && core0_request) w_next = S_OWN0;
        else                                   w_next = S_OWN1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Outputs: grants decoded from state, RAM command steered from the owner.
  always_comb begin
    core0_grant = (r_state == S_OWN0);
    core1_grant = (r_state == S_OWN1);
    dbg_state   = r_state;
    RAM_address = '0;
    RAM_data_in = '0;
    rw          = 1'b0;
    w_rd        = 1'b0;
    w_sel_oor   = 1'b0;
    if (w_xfer0) begin
      RAM_address = core0_address[RAM_AW-1:0];
      RAM_data_in = core0_data_in;
      rw          = core0_rw & ~w_oor0;
      w_rd        = ~core0_rw;
      w_sel_oor   = w_oor0;
    end else if (w_xfer1) begin
      RAM_address = core1_address[RAM_AW-1:0];
      RAM_data_in = core1_data_in;
      rw          = core1_rw & ~w_oor1;
      w_rd        = ~core1_rw;
      w_sel_oor   = w_oor1;
    end
  end

  // Pending read: remembers who issued it, so a read in flight across a
  // handoff still returns to its original owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_valid <= 1'b0;
      r_pend_owner <= 1'b0;
      r_pend_oor   <= 1'b0;
    end else begin
      r_pend_valid <= w_rd;
      r_pend_owner <= w_xfer1;
      r_pend_oor   <= w_sel_oor;
    end
  end

  assign w_rdata      = r_pend_oor ? OOR_DATA : RAM_data_out;
  assign core0_rvalid = r_pend_valid & ~r_pend_owner;
  assign core1_rvalid = r_pend_valid &  r_pend_owner;

  // Hold registers keep the last returned value visible between strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hold0 <= '0;
      r_hold1 <= '0;
    end else begin
      if (core0_rvalid) r_hold0 <= w_rdata;
      if (core1_rvalid) r_hold1 <= w_rdata;
    end
  end

  assign core0_data_out = core0_rvalid ? w_rdata : r_hold0;
  assign core1_data_out = core1_rvalid ? w_rdata : r_hold1;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, rw0, req1, rw1;
  logic [9:0] addr0, addr1;
  logic [7:0] din0, din1;
  logic       grant0, grant1, rvalid0, rvalid1;
  logic [7:0] dout0, dout1;
  logic [8:0] ram_addr;
  logic [7:0] ram_din, ram_dout;
  logic       ram_rw;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];     // {owner, data}
  logic [7:0] model_mem [0:511];
  logic [7:0] ram [0:511];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bus_arbiter_rr dut (
    .clk(clk), .reset(rst_n),
    .core0_request(req0), .core0_grant(grant0), .core0_rw(rw0),
    .core0_address(addr0), .core0_data_in(din0), .core0_data_out(dout0),
    .core0_rvalid(rvalid0),
    .core1_request(req1), .core1_grant(grant1), .core1_rw(rw1),
    .core1_address(addr1), .core1_data_in(din1), .core1_data_out(dout1),
    .core1_rvalid(rvalid1),
    .RAM_address(ram_addr), .RAM_data_in(ram_din), .RAM_data_out(ram_dout),
    .rw(ram_rw), .dbg_state(dbg_state)
  );

  // Synchronous RAM: read data valid the cycle after the address.
  always @(posedge clk) begin
    if (ram_rw) ram[ram_addr] <= ram_din;
    ram_dout <= ram[ram_addr];
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drv0(input logic rq, input logic w, input logic [9:0] a, input logic [7:0] d);
    #1;
    req0 = rq; rw0 = w; addr0 = a; din0 = d;
    if (rq && w && a < 10'd512) model_mem[a[8:0]] = d;
  endtask

  task automatic drv1(input logic rq, input logic w, input logic [9:0] a, input logic [7:0] d);
    #1;
    req1 = rq; rw1 = w; addr1 = a; din1 = d;
    if (rq && w && a < 10'd512) model_mem[a[8:0]] = d;
  endtask

  task automatic exp_read(input logic owner, input logic [9:0] a);
    if (a >= 10'd512) exp_q.push_back({owner, 8'hFF});
    else              exp_q.push_back({owner, model_mem[a[8:0]]});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [8:0] e;
    if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rvalid", {30'd0, rvalid1, rvalid0}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_owner", {31'd0, rvalid1}, {31'd0, e[8]});
        chk("rd_data", {24'd0, (rvalid1 ? dout1 : dout0)}, {24'd0, e[7:0]});
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int g0cnt, g1cnt, first_g1, regrant;
    logic both_seen;
    logic [7:0] d;

    for (int i = 0; i < 512; i++) begin
      ram[i]       = 8'(i) ^ 8'h5C;
      model_mem[i] = 8'(i) ^ 8'h5C;
    end
    rst_n = 1'b0;
    req0 = 0; rw0 = 0; addr0 = '0; din0 = '0;
    req1 = 0; rw1 = 0; addr1 = '0; din1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_grant0", grant0, 0);
    chk("rst_grant1", grant1, 0);
    chk("rst_rvalid", {rvalid1, rvalid0}, 0);
    chk("rst_dout0", dout0, 8'h00);
    chk("rst_dout1", dout1, 8'h00);
    chk("rst_state", dbg_state, 0);
    #1 rst_n = 1'b1;

    // Single request: one-cycle grant latency, release back to IDLE
    @(negedge clk); drv0(1, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t1_grant0", grant0, 1);
    chk("t1_grant1", grant1, 0);
    drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t1_release_grant0", grant0, 0);
    chk("t1_release_state", dbg_state, 0);

    // Tie after reset: core0 first, handoff without gap, core0 wins next tie
    #1 rst_n = 1'b0;
    @(negedge clk); #1 rst_n = 1'b1;
    @(negedge clk); drv0(1, 0, 10'h000, 8'h00); drv1(1, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t2_tie_grant0", grant0, 1);
    chk("t2_tie_grant1", grant1, 0);
    drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t2_handoff_grant1", grant1, 1);
    chk("t2_handoff_grant0", grant0, 0);
    drv1(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t2_idle", dbg_state, 0);
    drv0(1, 0, 10'h000, 8'h00); drv1(1, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t2_tie2_grant0", grant0, 1);
    chk("t2_tie2_grant1", grant1, 0);
    drv0(0, 0, 10'h000, 8'h00); drv1(0, 0, 10'h000, 8'h00);
    @(negedge clk);

    // Core0 write then back-to-back reads
    drv0(1, 1, 10'h3FF, 8'h00);     // request with a dropped write until granted
    @(negedge clk);
    chk("t3_grant0", grant0, 1);
    drv0(1, 1, 10'h005, 8'hA5);
    #1;
    chk("t3_wr_rw", ram_rw, 1);
    chk("t3_wr_addr", ram_addr, 9'h005);
    chk("t3_wr_data", ram_din, 8'hA5);
    @(negedge clk); drv0(1, 1, 10'h000, 8'h5A);
    @(negedge clk); drv0(1, 0, 10'h005, 8'h00); exp_read(0, 10'h005);
    #1 chk("t3_rd_rw", ram_rw, 0);
    @(negedge clk);
    chk("t3_rvalid0", rvalid0, 1);
    drv0(1, 0, 10'h000, 8'h00); exp_read(0, 10'h000);
    @(negedge clk); drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t3_rvalid_low", rvalid0, 0);
    chk("t3_dout0_hold", dout0, 8'h5A);

    // Random writes then back-to-back reads on core0
    base = $urandom_range(16, 500);
    drv0(1, 1, 10'h3FF, 8'h00);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      d = 8'($urandom_range(0, 255));
      drv0(1, 1, 10'(base + i), d);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      drv0(1, 0, 10'(base + i), 8'h00); exp_read(0, 10'(base + i));
      @(negedge clk);
    end
    drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);

    // Out-of-range on core1: write dropped, read returns FF
    drv1(1, 1, 10'h3FF, 8'h00);
    @(negedge clk);
    chk("t4_grant1", grant1, 1);
    drv1(1, 1, 10'h200, 8'h3C);
    #1 chk("t4_oor_wr_rw", ram_rw, 0);
    @(negedge clk); drv1(1, 0, 10'h200, 8'h00); exp_read(1, 10'h200);
    @(negedge clk); drv1(1, 0, 10'h000, 8'h00); exp_read(1, 10'h000);
    @(negedge clk); drv1(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t4_dout1_hold", dout1, 8'h5A);

    // Tenure: core0 holds 40 cycles, core1 requests at cycle 5
    g0cnt = 0; g1cnt = 0; first_g1 = -1; regrant = -1; both_seen = 1'b0;
    drv0(1, 1, 10'h3FF, 8'h00);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (grant0 && grant1) both_seen = 1'b1;
      if (grant0 && first_g1 < 0) g0cnt++;
      if (grant1) begin
        g1cnt++;
        if (first_g1 < 0) first_g1 = c;
      end
      if (grant0 && first_g1 >= 0 && regrant < 0) regrant = c;
      if (c == 5)  drv1(1, 1, 10'h3FF, 8'h00);
      if (c == 20) drv1(0, 0, 10'h000, 8'h00);
    end
    chk("t5_grant0_cycles", g0cnt, 16);
    chk("t5_grant1_first", first_g1, 17);
    chk("t5_grant1_cycles", g1cnt, 4);
    chk("t5_regrant0", regrant, 21);
    chk("t5_exclusive", both_seen, 0);
    drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    chk("t5_idle", dbg_state, 0);

    // Reset while a read is pending
    drv0(1, 1, 10'h3FF, 8'h00);
    @(negedge clk);
    drv0(1, 0, 10'h005, 8'h00);   // read that must be discarded
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_grant0", grant0, 0);
    chk("t6_grant1", grant1, 0);
    chk("t6_rvalid", {rvalid1, rvalid0}, 0);
    chk("t6_dout0", dout0, 8'h00);
    chk("t6_dout1", dout1, 8'h00);
    drv0(0, 0, 10'h000, 8'h00);
    @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t6_state", dbg_state, 0);
    chk("sb_queue_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
